// File: rtl/hamming74_enc_tx_if.sv
// Upstream word handshake into the Hamming(7,4) transmitter, with the
// per-word error-injection controls that travel alongside the data.
interface hamming74_enc_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       inj_en;
    logic [2:0] inj_pos;

    modport master (output in_valid, in_data, inj_en, inj_pos, input in_ready);
    modport slave  (input in_valid, in_data, inj_en, inj_pos, output in_ready);
endinterface

// File: rtl/hamming74_enc_tx.sv
// Hamming(7,4) encoder with codeword FIFO and LSB-first serializer.
// An optional single-bit flip per word lets downstream correction be exercised.
module hamming74_enc_tx #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hamming74_enc_tx_if.slave up,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    logic [6:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full, empty, push, pop, last_bit;
    logic [6:0]       cw, flip;

    state_t           state_q;
    logic [6:0]       sr_q;
    logic [2:0]       bit_q;
    logic [3:0]       gap_q;
    logic             sv_q, fs_q, fd_q;
    logic [CNT_W-1:0] fcnt_q;

    // Parity bits cover {d0,d1,d3}, {d0,d2,d3}, {d1,d2,d3}; pos 7 means no flip.
    always_comb begin
        cw   = {up.in_data[1] ^ up.in_data[2] ^ up.in_data[3],
                up.in_data[0] ^ up.in_data[2] ^ up.in_data[3],
                up.in_data[0] ^ up.in_data[1] ^ up.in_data[3],
                up.in_data};
        flip = '0;
        if (up.inj_en && up.inj_pos != 3'd7)
            flip = 7'(1) << up.inj_pos;
    end

    assign full        = (cnt_q == (AW+1)'(DEPTH));
    assign empty       = (cnt_q == '0);
    assign up.in_ready = ~full;
    assign push        = up.in_valid & ~full;
    assign last_bit    = (state_q == SHIFT) && (bit_q == 3'd6);
    // Head is taken whenever the serializer is (or is about to be) free.
    assign pop = ~empty && ((state_q == IDLE) ||
                            (state_q == GAP && gap_q == 4'd0) ||
                            (last_bit && GAP_CYCLES == 0));

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= cw ^ flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sv_q    <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            if (last_bit) fcnt_q <= fcnt_q + CNT_W'(1);
            if (pop) begin
                state_q <= SHIFT;
                sr_q    <= mem_q[rd_q];
                bit_q   <= '0;
                sv_q    <= 1'b1;
                fs_q    <= 1'b1;
                fd_q    <= 1'b0;
            end else begin
                case (state_q)
                    SHIFT: begin
                        if (last_bit) begin
                            state_q <= (GAP_CYCLES > 0) ? GAP : IDLE;
                            gap_q   <= GAP_INIT;
                            sr_q    <= '0;
                            sv_q    <= 1'b0;
                            fs_q    <= 1'b0;
                            fd_q    <= 1'b0;
                        end else begin
                            sr_q  <= {1'b0, sr_q[6:1]};
                            bit_q <= bit_q + 3'd1;
                            fs_q  <= 1'b0;
                            fd_q  <= (bit_q == 3'd5);
                        end
                    end
                    GAP: begin
                        if (gap_q == 4'd0) state_q <= IDLE;
                        else               gap_q   <= gap_q - 4'd1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // sr_q is cleared outside SHIFT, so its LSB doubles as the idle-low line.
    assign ser_out     = sr_q[0];
    assign ser_valid   = sv_q;
    assign frame_start = fs_q;
    assign frame_done  = fd_q;
    assign frame_cnt   = fcnt_q;
    assign busy        = (state_q != IDLE) || ~empty;
endmodule
